// File: rtl/mmul_result_collector_if.sv
// Matrix handshake bundle between the result collector and its consumer.
// master drives data/valid, slave drives ready.
interface mmul_result_collector_if #(
  parameter int SLICE_W = 8
);
  logic [16*SLICE_W-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/mmul_result_collector.sv
// Ping-pong collector: packs 4 Q16.16 elements into a 2x2 matrix.
// Optional partial-matrix timeout: define MMUL_COLLECTOR_TIMEOUT_EN.
module mmul_result_collector #(
  parameter int SLICE_W        = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SLICE_W-1:0] Resint_A,
  input  logic [SLICE_W-1:0] Resint_B,
  input  logic [SLICE_W-1:0] Resdec_A,
  input  logic [SLICE_W-1:0] Resdec_B,
  input  logic               out_rdy,
  mmul_result_collector_if.master m,
  output logic [1:0]         pending,
  output logic               ovf,
  input  logic               ovf_clr
`ifdef MMUL_COLLECTOR_TIMEOUT_EN
  ,
  output logic               tmo
`endif
);

  localparam int EW = 4*SLICE_W;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    STALL
  } state_t;

  state_t               state;
  logic [3:0][EW-1:0]   mem [2];
  logic [1:0]           full;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [1:0]           wr_idx;

  logic [EW-1:0]        elem;
  logic                 pop;
  logic                 accept;
  logic                 drop;
  logic                 done;
  logic                 abort;
  logic [1:0]           full_n;
  logic                 rd_bank_n;
  logic [3:0][EW-1:0]   view_n;

  assign elem   = {Resint_A, Resint_B, Resdec_A, Resdec_B};
  assign pop    = m.m_valid & m.m_ready;
  assign accept = out_rdy & ~full[wr_bank];
  assign drop   = out_rdy & full[wr_bank];
  assign done   = accept & (wr_idx == 2'd3);

`ifdef MMUL_COLLECTOR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  assign abort = (state == COLLECT) & ~out_rdy &
                 (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  // Outputs are registered from next-state, so m_data mirrors the bank
  // including an element landing in it on this same edge.
  always_comb begin
    full_n    = full;
    rd_bank_n = rd_bank ^ pop;
    if (pop)
      full_n[rd_bank] = 1'b0;
    if (done)
      full_n[wr_bank] = 1'b1;
    view_n = mem[rd_bank_n];
    if (accept && (wr_bank == rd_bank_n))
      view_n[~wr_idx] = elem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem       <= '{default: '0};
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      m.m_valid <= 1'b0;
      m.m_data  <= '0;
      pending   <= '0;
      ovf       <= 1'b0;
`ifdef MMUL_COLLECTOR_TIMEOUT_EN
      cnt       <= '0;
      tmo       <= 1'b0;
`endif
    end else begin
      full      <= full_n;
      rd_bank   <= rd_bank_n;
      m.m_valid <= full_n[rd_bank_n];
      m.m_data  <= view_n;
      pending   <= {1'b0, full_n[0]} + {1'b0, full_n[1]};

      if (accept)
        mem[wr_bank][~wr_idx] <= elem;

      if (drop)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;

`ifdef MMUL_COLLECTOR_TIMEOUT_EN
      if (state != COLLECT || out_rdy || abort)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (abort)
        tmo <= 1'b1;
      else if (ovf_clr)
        tmo <= 1'b0;
`endif

      unique case (state)
        IDLE: begin
          if (accept) begin
            wr_idx <= 2'd1;
            state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (abort) begin
            wr_idx <= '0;
            state  <= IDLE;
          end else if (accept) begin
            if (wr_idx == 2'd3) begin
              wr_idx  <= '0;
              wr_bank <= ~wr_bank;
              state   <= full[~wr_bank] ? STALL : IDLE;
            end else begin
              wr_idx <= wr_idx + 2'd1;
            end
          end
        end
        STALL: begin
          // Target bank freed by an earlier pop: usable on this edge.
          if (!full[wr_bank]) begin
            if (out_rdy) begin
              wr_idx <= 2'd1;
              state  <= COLLECT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
